smpl_mem: RTL and testbench

SMPL_MEM -- requirements
Module: smpl_mem

---
 rtl/smpl_mem.sv | 165 ++++++++++++++++
 tb/tb_smpl_mem.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/smpl_mem.sv
// smpl_mem: instruction and data memories for a small core, plus a byte-serial
// program loader that fills instruction memory while the core is held in reset.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   iaddr  / idata          instruction fetch (1-cycle synchronous read)
//   daddr, wdata, rdata     data port; wenbl writes, renbl (without wenbl) reads
//   renbl, wenbl            data read / write requests
//   ld_start, ld_end        single-cycle pulses opening / closing a load session
//   ld_valid, ld_byte       program byte stream, high byte of each word first
//   ld_ready                loader accepts a byte when ld_valid && ld_ready
//   core_hold               high while a load session is open
//   ld_count                words written in the current or last session
module smpl_mem #(
  parameter int unsigned IMEM_AW = 10,
  parameter int unsigned DMEM_AW = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [12:0] iaddr,
  output logic [15:0] idata,
  input  logic [12:0] daddr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  input  logic        renbl,
  input  logic        wenbl,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  input  logic        ld_end,
  output logic        ld_ready,
  output logic        core_hold,
  output logic [13:0] ld_count
);

  localparam int unsigned IMEM_DEPTH = 1 << IMEM_AW;
  localparam int unsigned DMEM_DEPTH = 1 << DMEM_AW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HI   = 2'd1,
    S_LO   = 2'd2
  } ld_state_e;

  logic [15:0] imem [IMEM_DEPTH];
  logic [15:0] dmem [DMEM_DEPTH];

  ld_state_e          state_q, state_d;
  logic [IMEM_AW-1:0] ptr_q, ptr_d;
  logic [13:0]        ld_count_q, ld_count_d;
  logic [7:0]         hold_q, hold_d;
  logic               ld_ready_q, ld_ready_d;
  logic               core_hold_q, core_hold_d;
  logic [15:0]        idata_q;
  logic [15:0]        rdata_q;
  logic               imem_we_c;
  logic               accept_c;
  logic               i_in_range_c;
  logic               d_in_range_c;

  // Any address bit above the implemented depth marks the access out of range.
  assign i_in_range_c = (13'(iaddr >> IMEM_AW) == 13'd0);
  assign d_in_range_c = (13'(daddr >> DMEM_AW) == 13'd0);
  assign accept_c     = ld_valid && ld_ready_q;

  assign idata     = idata_q;
  assign rdata     = rdata_q;
  assign ld_ready  = ld_ready_q;
  assign core_hold = core_hold_q;
  assign ld_count  = ld_count_q;

  // Loader state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      ld_count_q  <= 14'd0;
      hold_q      <= 8'd0;
      ld_ready_q  <= 1'b0;
      core_hold_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      ld_count_q  <= ld_count_d;
      hold_q      <= hold_d;
      ld_ready_q  <= ld_ready_d;
      core_hold_q <= core_hold_d;
    end
  end

  // Loader next state; ld_start restarts from any state and outranks ld_end,
  // and a byte accepted together with ld_end is processed before closing.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    ld_count_d = ld_count_q;
    hold_d     = hold_q;
    imem_we_c  = 1'b0;

    if (ld_start) begin
      state_d    = S_HI;
      ptr_d      = '0;
      ld_count_d = 14'd0;
      hold_d     = 8'd0;
    end else begin
      unique case (state_q)
        S_HI: begin
          if (accept_c) begin
            hold_d  = ld_byte;
            state_d = S_LO;
          end
          if (ld_end) begin
            state_d = S_IDLE;
          end
        end
        S_LO: begin
          if (accept_c) begin
            imem_we_c  = 1'b1;
            ld_count_d = ld_count_q + 14'd1;
            // Last word of the array closes the session; the pointer never wraps.
            if (ptr_q == {IMEM_AW{1'b1}}) begin
              state_d = S_IDLE;
            end else begin
              ptr_d   = ptr_q + IMEM_AW'(1);
              state_d = S_HI;
            end
          end
          if (ld_end) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    ld_ready_d  = (state_d != S_IDLE);
    core_hold_d = (state_d != S_IDLE);
  end

  // Memory arrays: not reset, written only on enabled in-range cycles.
  always_ff @(posedge clock) begin
    if (imem_we_c) begin
      imem[ptr_q] <= {hold_q, ld_byte};
    end
    if (wenbl && d_in_range_c) begin
      dmem[daddr[DMEM_AW-1:0]] <= wdata;
    end
  end

  // Registered read ports; nonblocking reads give old data on collisions.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idata_q <= 16'h0000;
      rdata_q <= 16'h0000;
    end else begin
      idata_q <= i_in_range_c ? imem[iaddr[IMEM_AW-1:0]] : 16'h0000;
      if (renbl && !wenbl) begin
        rdata_q <= d_in_range_c ? dmem[daddr[DMEM_AW-1:0]] : 16'h0000;
      end
    end
  end

endmodule

// File: tb/tb_smpl_mem.sv
// Directed testbench for smpl_mem: a default-size instance and an IMEM_AW=2
// instance share all inputs; the small one exercises the full-memory stop.
module tb_smpl_mem;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [12:0] iaddr = '0;
  logic [12:0] daddr = '0;
  logic [15:0] wdata = '0;
  logic        renbl = 1'b0;
  logic        wenbl = 1'b0;
  logic        ld_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_byte = '0;
  logic        ld_end = 1'b0;

  logic [15:0] idata, rdata, idata_s, rdata_s;
  logic        ld_ready, core_hold, ld_ready_s, core_hold_s;
  logic [13:0] ld_count, ld_count_s;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  smpl_mem #(.IMEM_AW(10), .DMEM_AW(10)) dut (
    .clock(clock), .reset(reset), .iaddr(iaddr), .idata(idata),
    .daddr(daddr), .wdata(wdata), .rdata(rdata), .renbl(renbl), .wenbl(wenbl),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_end(ld_end),
    .ld_ready(ld_ready), .core_hold(core_hold), .ld_count(ld_count)
  );

  smpl_mem #(.IMEM_AW(2), .DMEM_AW(10)) dut_s (
    .clock(clock), .reset(reset), .iaddr(iaddr), .idata(idata_s),
    .daddr(daddr), .wdata(wdata), .rdata(rdata_s), .renbl(renbl), .wenbl(wenbl),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_end(ld_end),
    .ld_ready(ld_ready_s), .core_hold(core_hold_s), .ld_count(ld_count_s)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    ld_start = 1'b1; tick(); ld_start = 1'b0;
  endtask

  task automatic pulse_end();
    ld_end = 1'b1; tick(); ld_end = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    ld_valid = 1'b1; ld_byte = b; tick(); ld_valid = 1'b0;
  endtask

  task automatic fetch(input logic [12:0] a);
    iaddr = a; tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; #1;
    checks += 5;
    if (idata !== 16'h0000) begin failures++; $display("FAIL reset_idata got %h exp 0000", idata); end
    if (rdata !== 16'h0000) begin failures++; $display("FAIL reset_rdata got %h exp 0000", rdata); end
    if (ld_ready !== 1'b0) begin failures++; $display("FAIL reset_ld_ready got %b exp 0", ld_ready); end
    if (core_hold !== 1'b0) begin failures++; $display("FAIL reset_core_hold got %b exp 0", core_hold); end
    if (ld_count !== 14'd0) begin failures++; $display("FAIL reset_ld_count got %0d exp 0", ld_count); end
    tick(); tick();
    reset = 1'b0; tick();
  endtask

  task automatic test_load();
    pulse_start();
    checks += 2;
    if (core_hold !== 1'b1) begin failures++; $display("FAIL load_hold_on got %b exp 1", core_hold); end
    if (ld_ready !== 1'b1) begin failures++; $display("FAIL load_ready_on got %b exp 1", ld_ready); end
    send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
    checks += 2;
    if (ld_count !== 14'd2) begin failures++; $display("FAIL load_count got %0d exp 2", ld_count); end
    if (core_hold !== 1'b1) begin failures++; $display("FAIL load_hold_before_end got %b exp 1", core_hold); end
    pulse_end();
    checks += 3;
    if (core_hold !== 1'b0) begin failures++; $display("FAIL load_hold_off got %b exp 0", core_hold); end
    if (ld_ready !== 1'b0) begin failures++; $display("FAIL load_ready_off got %b exp 0", ld_ready); end
    if (ld_count !== 14'd2) begin failures++; $display("FAIL load_count_held got %0d exp 2", ld_count); end
  endtask

  task automatic test_fetch();
    fetch(13'd0);
    checks++;
    if (idata !== 16'h1234) begin failures++; $display("FAIL fetch_w0 got %h exp 1234", idata); end
    iaddr = 13'd1; #2;
    checks++;
    if (idata !== 16'h1234) begin failures++; $display("FAIL fetch_latency got %h exp 1234", idata); end
    tick();
    checks++;
    if (idata !== 16'hABCD) begin failures++; $display("FAIL fetch_w1 got %h exp abcd", idata); end
    fetch(13'h0400);
    checks++;
    if (idata !== 16'h0000) begin failures++; $display("FAIL fetch_oor got %h exp 0000", idata); end
  endtask

  task automatic test_fetch_collision();
    iaddr = 13'd0;
    pulse_start();
    send_byte(8'h55);
    send_byte(8'h66);
    checks++;
    if (idata !== 16'h1234) begin failures++; $display("FAIL collide_old got %h exp 1234", idata); end
    tick();
    checks++;
    if (idata !== 16'h5566) begin failures++; $display("FAIL collide_new got %h exp 5566", idata); end
    pulse_end();
  endtask

  task automatic test_data();
    wenbl = 1'b1; daddr = 13'd5; wdata = 16'hBEEF; tick();
    wenbl = 1'b0; renbl = 1'b1; tick();
    checks++;
    if (rdata !== 16'hBEEF) begin failures++; $display("FAIL data_read got %h exp beef", rdata); end
    wenbl = 1'b1; wdata = 16'h1111; tick();
    checks++;
    if (rdata !== 16'hBEEF) begin failures++; $display("FAIL data_rw_hold got %h exp beef", rdata); end
    wenbl = 1'b0; tick();
    checks++;
    if (rdata !== 16'h1111) begin failures++; $display("FAIL data_new got %h exp 1111", rdata); end
    renbl = 1'b0; daddr = 13'd6; tick();
    checks++;
    if (rdata !== 16'h1111) begin failures++; $display("FAIL data_idle_hold got %h exp 1111", rdata); end
    wenbl = 1'b1; daddr = 13'h0405; wdata = 16'hDEAD; tick();
    wenbl = 1'b0; renbl = 1'b1; daddr = 13'd5; tick();
    checks++;
    if (rdata !== 16'h1111) begin failures++; $display("FAIL data_no_alias got %h exp 1111", rdata); end
    daddr = 13'h0405; tick();
    checks++;
    if (rdata !== 16'h0000) begin failures++; $display("FAIL data_oor got %h exp 0000", rdata); end
    renbl = 1'b0;
  endtask

  task automatic test_partial();
    pulse_start();
    send_byte(8'h77);
    pulse_end();
    checks += 2;
    if (ld_count !== 14'd0) begin failures++; $display("FAIL partial_count got %0d exp 0", ld_count); end
    if (ld_ready !== 1'b0) begin failures++; $display("FAIL partial_idle got %b exp 0", ld_ready); end
    fetch(13'd0);
    checks++;
    if (idata !== 16'h5566) begin failures++; $display("FAIL partial_nowrite got %h exp 5566", idata); end
    // Final byte arriving with ld_end still completes its word.
    pulse_start();
    send_byte(8'h01);
    ld_end = 1'b1; send_byte(8'h02); ld_end = 1'b0;
    checks += 2;
    if (ld_count !== 14'd1) begin failures++; $display("FAIL end_byte_count got %0d exp 1", ld_count); end
    if (core_hold !== 1'b0) begin failures++; $display("FAIL end_byte_idle got %b exp 0", core_hold); end
    fetch(13'd0);
    checks++;
    if (idata !== 16'h0102) begin failures++; $display("FAIL end_byte_word got %h exp 0102", idata); end
  endtask

  task automatic test_full();
    pulse_start();
    ld_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ld_byte = 8'(i + 1);
      tick();
      if (i == 7) begin
        checks += 2;
        if (ld_ready_s !== 1'b0) begin failures++; $display("FAIL full_ready got %b exp 0", ld_ready_s); end
        if (ld_count_s !== 14'd4) begin failures++; $display("FAIL full_count got %0d exp 4", ld_count_s); end
      end
    end
    ld_valid = 1'b0;
    checks++;
    if (ld_count_s !== 14'd4) begin failures++; $display("FAIL full_count_after got %0d exp 4", ld_count_s); end
    pulse_end();
    fetch(13'd0);
    checks++;
    if (idata_s !== 16'h0102) begin failures++; $display("FAIL full_w0 got %h exp 0102", idata_s); end
    fetch(13'd3);
    checks++;
    if (idata_s !== 16'h0708) begin failures++; $display("FAIL full_w3 got %h exp 0708", idata_s); end
    fetch(13'd4);
    checks++;
    if (idata_s !== 16'h0000) begin failures++; $display("FAIL full_oor got %h exp 0000", idata_s); end
  endtask

  task automatic test_restart();
    pulse_start();
    send_byte(8'hAA);
    pulse_start();
    send_byte(8'h11);
    send_byte(8'h22);
    pulse_end();
    checks++;
    if (ld_count !== 14'd1) begin failures++; $display("FAIL restart_count got %0d exp 1", ld_count); end
    fetch(13'd0);
    checks++;
    if (idata !== 16'h1122) begin failures++; $display("FAIL restart_word got %h exp 1122", idata); end
    // Simultaneous start and end from idle opens a session.
    ld_start = 1'b1; ld_end = 1'b1; tick(); ld_start = 1'b0; ld_end = 1'b0;
    checks++;
    if (core_hold !== 1'b1) begin failures++; $display("FAIL start_over_end got %b exp 1", core_hold); end
    pulse_end();
  endtask

  task automatic test_reset_midload();
    pulse_start();
    send_byte(8'h99); send_byte(8'h88); send_byte(8'h77);
    reset = 1'b1; #1;
    checks += 3;
    if (core_hold !== 1'b0) begin failures++; $display("FAIL midrst_hold got %b exp 0", core_hold); end
    if (ld_count !== 14'd0) begin failures++; $display("FAIL midrst_count got %0d exp 0", ld_count); end
    if (ld_ready !== 1'b0) begin failures++; $display("FAIL midrst_ready got %b exp 0", ld_ready); end
    tick();
    reset = 1'b0;
    fetch(13'd0);
    checks++;
    if (idata !== 16'h9988) begin failures++; $display("FAIL midrst_kept got %h exp 9988", idata); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_fetch();
    test_fetch_collision();
    test_data();
    test_partial();
    test_full();
    test_restart();
    test_reset_midload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
